// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the 5-bit PRBS (x^5+x^3+1) generator/checker
// family. Holds the sequence length, the feedback taps (identical to the
// generator's), the checker state encoding and the bit-prediction helper.
package prbs_pkg;

  localparam int PRBS_LEN = 5;

  // Feedback taps into the history word, where h[0] is the newest bit:
  // b[n] = b[n-5] ^ b[n-3]  ->  h[4] ^ h[2].
  localparam int TAP_A = 4;
  localparam int TAP_B = 2;

  typedef enum logic [0:0] {
    SEED = 1'b0,
    LOCK = 1'b1
  } state_e;

  // Next expected stream bit given the last PRBS_LEN received bits.
  function automatic logic prbs_pred(input logic [PRBS_LEN-1:0] h);
    return h[TAP_A] ^ h[TAP_B];
  endfunction

endpackage

// File: rtl/prbs5_hist.sv
// prbs5_hist: 5-bit stream history register with the recurrence predictor.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (history to zero)
//   clear    in   synchronous clear of the history (loss of lock)
//   shift_en in   shift one bit into the history this cycle
//   use_pred in   1: shift in the predicted bit (flywheel), 0: shift in in_bit
//   in_bit   in   received stream bit
//   pred     out  predicted next bit from the current history
//   h_zero   out  the history that a shift this cycle would produce is all-zero
module prbs5_hist
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic shift_en,
  input  logic use_pred,
  input  logic in_bit,
  output logic pred,
  output logic h_zero
);

  logic [PRBS_LEN-1:0] h_r;
  logic [PRBS_LEN-1:0] h_shift_s;
  logic                shift_bit_s;
  logic                pred_s;

  // Prediction, shift-in selection and the candidate next history.
  always_comb begin
    pred_s = prbs_pred(h_r);
    if (use_pred) begin
      shift_bit_s = pred_s;
    end else begin
      shift_bit_s = in_bit;
    end
    h_shift_s = {h_r[PRBS_LEN-2:0], shift_bit_s};
  end

  // History register; clear takes priority over shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_r <= 5'b00000;
    end else if (clear) begin
      h_r <= 5'b00000;
    end else if (shift_en) begin
      h_r <= h_shift_s;
    end else begin
      h_r <= h_r;
    end
  end

  assign pred   = pred_s;
  // Lookup state of the LFSR: an all-zero history must never be locked onto.
  assign h_zero = (h_shift_s == 5'b00000);

endmodule

// File: rtl/prbs5_checker.sv
// prbs5_checker: self-synchronising checker for an x^5+x^3+1 bit stream.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, overrides all other inputs
//   clr      in   synchronous clear of err_cnt and chk_cnt only
//   in_vld   in   in_bit is valid this cycle
//   in_bit   in   received stream bit
//   locked   out  checker is in the LOCK state
//   err      out  one-cycle pulse per mismatched bit
//   err_cnt  out  saturating mismatch count
//   chk_cnt  out  saturating count of bits compared while locked
// All outputs are registered and reflect the valid bit of the previous edge.
module prbs5_checker
  import prbs_pkg::*;
#(
  parameter int ERR_LOSS = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_vld,
  input  logic             in_bit,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt
);

  localparam logic [2:0]       ERR_LOSS_C = 3'(ERR_LOSS);
  localparam logic [2:0]       FILL_MAX   = 3'd5;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_e           state_r;
  state_e           state_nxt_s;
  logic [2:0]       fill_r;
  logic [2:0]       fill_nxt_s;
  logic [2:0]       cons_r;
  logic [2:0]       cons_nxt_s;
  logic             locked_r;
  logic             err_r;
  logic             err_nxt_s;
  logic [CNT_W-1:0] err_cnt_r;
  logic [CNT_W-1:0] chk_cnt_r;
  logic             err_inc_s;
  logic             chk_inc_s;
  logic             hist_clear_s;
  logic             hist_shift_s;
  logic             hist_use_pred_s;
  logic             pred_s;
  logic             h_zero_s;
  logic             mismatch_s;
  logic             loss_s;
  logic             seed_done_s;

  prbs5_hist u_hist (
    .clk      (clk),
    .rst      (rst),
    .clear    (hist_clear_s),
    .shift_en (hist_shift_s),
    .use_pred (hist_use_pred_s),
    .in_bit   (in_bit),
    .pred     (pred_s),
    .h_zero   (h_zero_s)
  );

  // Event decode shared by the next-state and output logic.
  always_comb begin
    mismatch_s  = in_bit ^ pred_s;
    // fill of 4 before this shift means at least 5 bits after it.
    seed_done_s = in_vld && (fill_r >= 3'd4) && !h_zero_s;
    loss_s      = in_vld && mismatch_s && ((cons_r + 3'd1) >= ERR_LOSS_C);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SEED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SEED: begin
        if (seed_done_s) begin
          state_nxt_s = LOCK;
        end else begin
          state_nxt_s = SEED;
        end
      end
      LOCK: begin
        if (loss_s) begin
          state_nxt_s = SEED;
        end else begin
          state_nxt_s = LOCK;
        end
      end
      default: state_nxt_s = SEED;
    endcase
  end

  // FSM output logic: history control, fill/consecutive counters, error events.
  always_comb begin
    hist_clear_s    = 1'b0;
    hist_shift_s    = 1'b0;
    hist_use_pred_s = 1'b0;
    fill_nxt_s      = fill_r;
    cons_nxt_s      = cons_r;
    err_nxt_s       = 1'b0;
    err_inc_s       = 1'b0;
    chk_inc_s       = 1'b0;
    case (state_r)
      SEED: begin
        if (in_vld) begin
          hist_shift_s = 1'b1;
          if (fill_r == FILL_MAX) begin
            fill_nxt_s = FILL_MAX;
          end else begin
            fill_nxt_s = fill_r + 3'd1;
          end
        end else begin
          hist_shift_s = 1'b0;
        end
      end
      LOCK: begin
        if (in_vld) begin
          // Flywheel on the prediction so a single bad bit costs one error.
          hist_shift_s    = 1'b1;
          hist_use_pred_s = 1'b1;
          chk_inc_s       = 1'b1;
          if (mismatch_s) begin
            err_nxt_s  = 1'b1;
            err_inc_s  = 1'b1;
            cons_nxt_s = cons_r + 3'd1;
          end else begin
            cons_nxt_s = 3'd0;
          end
          if (loss_s) begin
            hist_clear_s = 1'b1;
            fill_nxt_s   = 3'd0;
            cons_nxt_s   = 3'd0;
          end else begin
            hist_clear_s = 1'b0;
          end
        end else begin
          hist_shift_s = 1'b0;
        end
      end
      default: begin
        hist_clear_s = 1'b1;
        fill_nxt_s   = 3'd0;
        cons_nxt_s   = 3'd0;
      end
    endcase
  end

  // Datapath registers: fill, consecutive count and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_r   <= 3'd0;
      cons_r   <= 3'd0;
      locked_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      fill_r   <= fill_nxt_s;
      cons_r   <= cons_nxt_s;
      locked_r <= (state_nxt_s == LOCK);
      err_r    <= err_nxt_s;
    end
  end

  // Saturating statistics counters; clr beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_r <= '0;
      chk_cnt_r <= '0;
    end else if (clr) begin
      err_cnt_r <= '0;
      chk_cnt_r <= '0;
    end else begin
      if (err_inc_s) begin
        err_cnt_r <= sat_inc(err_cnt_r);
      end else begin
        err_cnt_r <= err_cnt_r;
      end
      if (chk_inc_s) begin
        chk_cnt_r <= sat_inc(chk_cnt_r);
      end else begin
        chk_cnt_r <= chk_cnt_r;
      end
    end
  end

  assign locked  = locked_r;
  assign err     = err_r;
  assign err_cnt = err_cnt_r;
  assign chk_cnt = chk_cnt_r;

endmodule
